// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each port owns a one-entry result slot that holds until the requester accepts it.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result
);

    logic last_grant;
    logic free0, free1;
    logic elig0, elig1;
    logic grant0, grant1;

    // A full slot counts as free when it is being drained this cycle.
    assign free0 = !rsp0_valid || rsp0_ready;
    assign free1 = !rsp1_valid || rsp1_ready;
    assign elig0 = req0_valid && free0;
    assign elig1 = req1_valid && free1;

    assign grant0 = elig0 && (!elig1 || last_grant);
    assign grant1 = elig1 && (!elig0 || !last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (grant0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (grant1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= 1'b1;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_result <= '0;
        end else begin
            if (grant0 || grant1)
                last_grant <= grant1;

            if (grant0) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= alu_result;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end

            if (grant1) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= alu_result;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: per-cycle vector tables with a result scoreboard per port.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [WIDTH-1:0] req0_a, req0_b, rsp0_result;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] req1_a, req1_b, rsp1_result;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [OPW-1:0]   alu_op;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    typedef struct {
        logic             v0;
        logic [WIDTH-1:0] a0, b0;
        logic [OPW-1:0]   op0;
        logic             r0;
        logic             v1;
        logic [WIDTH-1:0] a1, b1;
        logic [OPW-1:0]   op1;
        logic             r1;
        logic             g0, g1;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic logic [WIDTH-1:0] alu_f(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                               logic [OPW-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic vec_t mk(logic v0, int a0, int b0, int op0, logic r0,
                                logic v1, int a1, int b1, int op1, logic r1,
                                logic g0, logic g1);
        vec_t v;
        v.v0 = v0; v.a0 = WIDTH'(a0); v.b0 = WIDTH'(b0); v.op0 = OPW'(op0); v.r0 = r0;
        v.v1 = v1; v.a1 = WIDTH'(a1); v.b1 = WIDTH'(b1); v.op1 = OPW'(op1); v.r1 = r1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    // Shared ALU modelled in the bench.
    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
    );

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0; rsp0_ready = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0; rsp1_ready = 0;
    endtask

    task automatic apply(vec_t v, string tag);
        logic [127:0] exp_alu;
        @(negedge clk);
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0; rsp0_ready = v.r0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1; rsp1_ready = v.r1;
        #1;
        check({tag, " req0_ready"}, 128'(req0_ready), 128'(v.g0));
        check({tag, " req1_ready"}, 128'(req1_ready), 128'(v.g1));
        if (v.g0)      exp_alu = {64'(v.a0), 32'(v.b0), 32'(v.op0)};
        else if (v.g1) exp_alu = {64'(v.a1), 32'(v.b1), 32'(v.op1)};
        else           exp_alu = '0;
        check({tag, " alu_drive"}, {64'(alu_a), 32'(alu_b), 32'(alu_op)}, exp_alu);
        check({tag, " rsp0_valid"}, 128'(rsp0_valid), 128'(q0.size() != 0));
        if (q0.size() != 0) check({tag, " rsp0_result"}, 128'(rsp0_result), 128'(q0[0]));
        check({tag, " rsp1_valid"}, 128'(rsp1_valid), 128'(q1.size() != 0));
        if (q1.size() != 0) check({tag, " rsp1_result"}, 128'(rsp1_result), 128'(q1[0]));
        if (v.r0 && q0.size() != 0) void'(q0.pop_front());
        if (v.r1 && q1.size() != 0) void'(q1.pop_front());
        if (v.g0) q0.push_back(alu_f(v.a0, v.b0, v.op0));
        if (v.g1) q1.push_back(alu_f(v.a1, v.b1, v.op1));
    endtask

    initial begin
        //            v0 a0 b0 op r0  v1 a1 b1 op r1  g0 g1
        tbl_a.push_back(mk(1, 10, 5, 0, 1,  0, 0, 0, 0, 1,  1, 0)); // single port add
        tbl_a.push_back(mk(1, 10, 5, 1, 1,  0, 0, 0, 0, 1,  1, 0)); // back-to-back sub
        tbl_a.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 1,  0, 0)); // idle, drain
        tbl_a.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 1,  0, 0)); // idle, empty
        tbl_a.push_back(mk(0, 0, 0, 0, 1,   1, 8, 2, 1, 1,  0, 1)); // port 1 alone
        tbl_a.push_back(mk(0, 0, 0, 0, 1,   1, 3, 4, 0, 1,  0, 1)); // drain+refill port 1
        tbl_a.push_back(mk(1, 1, 1, 0, 0,   0, 0, 0, 0, 0,  1, 0)); // fill port 0, hold 1
        tbl_a.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0)); // both slots held

        tbl_b.push_back(mk(1, 10, 5, 0, 1,  1, 8, 2, 1, 1,  1, 0)); // contention: 0 first
        tbl_b.push_back(mk(1, 10, 5, 0, 1,  1, 8, 2, 1, 1,  0, 1));
        tbl_b.push_back(mk(1, 10, 5, 0, 1,  1, 8, 2, 1, 1,  1, 0));
        tbl_b.push_back(mk(1, 10, 5, 0, 1,  1, 8, 2, 1, 1,  0, 1));
        tbl_b.push_back(mk(1, 20, 3, 1, 0,  1, 8, 2, 1, 1,  1, 0)); // fill port 0, then hold
        tbl_b.push_back(mk(1, 7, 7, 2, 0,   1, 6, 9, 3, 1,  0, 1)); // back-pressure 1
        tbl_b.push_back(mk(1, 7, 7, 2, 0,   1, 5, 3, 4, 1,  0, 1)); // back-pressure 2
        tbl_b.push_back(mk(1, 7, 7, 2, 0,   1, 2, 2, 0, 1,  0, 1)); // back-pressure 3
        tbl_b.push_back(mk(1, 7, 12, 3, 1,  1, 2, 2, 0, 1,  1, 0)); // release: refill 0
        tbl_b.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 1,  0, 0));
        tbl_b.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 1,  0, 0));

        drive_idle();
        rst = 1'b1;
        #1;
        check("reset rsp0_valid", 128'(rsp0_valid), 128'(0));
        check("reset rsp1_valid", 128'(rsp1_valid), 128'(0));
        check("reset req0_ready", 128'(req0_ready), 128'(0));
        check("reset alu_drive", {64'(alu_a), 32'(alu_b), 32'(alu_op)}, 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("A%0d", i));

        // Both slots hold results; reset lands between edges and must clear them at once.
        @(negedge clk);
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        check("midrst rsp0_valid", 128'(rsp0_valid), 128'(0));
        check("midrst rsp1_valid", 128'(rsp1_valid), 128'(0));
        check("midrst rsp0_result", 128'(rsp0_result), 128'(0));
        check("midrst rsp1_result", 128'(rsp1_result), 128'(0));
        check("midrst req0_ready", 128'(req0_ready), 128'(0));
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("B%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares a single combinational `alu` instance between two requesters, e.g. the execute stage (port 0) and the address/branch-compare path (port 1). Each requester issues operand/op triples over a valid/ready handshake. The arbiter grants one request per cycle using round-robin priority and drives the shared ALU. It registers each result into a per-port response slot that is held until the requester accepts it.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width.
- `OPW`, default 4: ALU op-code width; the arbiter passes op codes through without decoding them.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  port 0 request present.
- `req0_ready`  out  1  port 0 request accepted this cycle (grant).
- `req0_a`, `req0_b`  in  WIDTH  port 0 operands.
- `req0_op`  in  OPW  port 0 ALU op.
- `rsp0_valid`  out  1  port 0 result slot full.
- `rsp0_ready`  in  1  port 0 consumes the result this cycle.
- `rsp0_result`  out  WIDTH  port 0 result.
- `req1_*`, `rsp1_*`: identical set for port 1.
- `alu_a`, `alu_b`  out  WIDTH  operands to the shared ALU.
- `alu_op`  out  OPW  op code to the shared ALU.
- `alu_result`  in  WIDTH  combinational result from the shared ALU.

## Operation
- **Slot free:** port n's slot is free when `rspn_valid==0`, or when `rspn_valid && rspn_ready` in the same cycle (drain and refill).
- **Eligibility:** port n is eligible when `reqn_valid` is high and its slot is free.
- **Arbitration:**
  - Only one eligible port: that port is granted.
  - Both eligible: the port that was not granted most recently wins.
  - `last_grant` updates only on an actual grant.
- **Grant:** `reqn_ready=1` for exactly the granted port; at most one ready is high per cycle. Ready is combinational from the valids, `last_grant` and the slot state; it never depends on `alu_result`.
- **ALU drive:**
  - `alu_a`/`alu_b`/`alu_op` mux the granted port's fields.
  - With no grant they drive all-zero.
- **Capture:** on the edge ending a grant cycle, `rspn_result <= alu_result` and `rspn_valid <= 1`.
- **Drain:** on the edge where `rspn_valid && rspn_ready` and there is no new grant to port n, `rspn_valid <= 0`. `rspn_result` holds its last value.
- **Stability:** `rspn_result` is stable while `rspn_valid` is high and unaccepted.
- **Ordering:** results on each port return in issue order; there is at most one result in flight per port.
- **Width rules:** no width conversion in the arbiter; the ALU defines overflow and wrap.
- **State:** `last_grant` (1 bit), `rsp0_valid`, `rsp1_valid`, `rsp0_result`, `rsp1_result`.

## Timing
- **Reset values:**
  - `rsp0_valid=0`, `rsp1_valid=0`.
  - `rsp0_result=0`, `rsp1_result=0`.
  - `last_grant=1`, so port 0 wins the first contention.
  - With no valid requests: `req*_ready=0`, and `alu_*` are zero.
- **Latency:** the request is accepted in cycle t and `rspn_valid` goes high in cycle t+1.
- **Throughput:**
  - A single port reaches 1 request/cycle if it asserts `rspn_ready` every cycle.
  - Two contending ports get 1 grant/cycle total, alternating.
- **Back-pressure:** while `rspn_valid=1` and `rspn_ready=0`, `reqn_ready=0` for that port. The other port is unaffected and may take every grant.
- **Simultaneous events:**
  - A drain and a new grant on the same port in the same cycle leave `rspn_valid` at 1 with the new result.
  - A port that is valid but blocked does not consume its round-robin turn.
- **Reset mid-operation:** both slots are cleared immediately (asynchronously) and pending results are lost. After deassertion the first contention again goes to port 0.
- **Combinational paths:** requester → ALU → slot register only. There is no path from `alu_result` to any output.

## Test plan
- **Reset:** assert `rst` mid-cycle with both slots full → `rsp0_valid`, `rsp1_valid` and both results are 0 immediately. `req0_ready=0` when no request is valid.
- **Single port:** port 0 only, `a=10`, `b=5`, `op=0000`, `rsp0_ready=1` → `req0_ready=1` in cycle t; `rsp0_valid=1` with `rsp0_result=15` in t+1. Then issue `op=0001` back-to-back → `rsp0_result=5` the next cycle.
- **Contention:**
  - Setup: both ports valid for 4 cycles; port 0 issues `10+5` and port 1 issues `8-2`; both ready always high.
  - First grant: port 0 (reset `last_grant=1`).
  - Subsequent grants: alternate 0,1,0,1.
  - Results alternate 15 and 6, one grant per cycle.
- **Back-pressure:** port 0's result is held (`rsp0_ready=0`) for 3 cycles while both ports are valid → `req0_ready=0` for those cycles and port 1 is granted every cycle. `rsp0_result` stays at its value. Raising `rsp0_ready` refills the slot in the same cycle it drains.
- **Idle:** no valid requests → `alu_a`, `alu_b` and `alu_op` are all 0, and no `rsp*_valid` rises.
- **Drain and refill on the same edge:** `rsp1_valid=1`, `rsp1_ready=1` and `req1_valid=1` with port 0 idle → `req1_ready=1`. `rsp1_valid` stays 1 on the next edge with the new result, never dropping low.
